// File: rtl/usb_out_ep_drain.sv
// Drains one USB OUT endpoint into a valid/ready byte stream through a small FWFT FIFO.
// Gets are credit-limited so every byte fetched from the endpoint always has a FIFO slot.
module usb_out_ep_drain #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     ep_data_avail,
  output logic                     ep_data_get,
  input  logic [7:0]               ep_data,
  output logic                     ep_stall,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [7:0]               byte_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pending_q, pending_d;
  logic [7:0]    mem_q [DEPTH];

  logic [AW:0]   credit_s;
  logic          pop_s;

  // The in-flight byte counts against credit so its slot is reserved at get time.
  always_comb begin
    credit_s    = count_q + (AW+1)'(pending_q);
    ep_data_get = !reset && enable && ep_data_avail && (credit_s < DEPTH_C);
    pop_s       = (count_q != '0) && byte_ready;
    pending_d   = ep_data_get;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (pending_q) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({pending_q, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
    end
  end

  // Storage is not reset; a byte pending at a reset edge is simply not written.
  always_ff @(posedge clk) begin
    if (pending_q && !reset) begin
      mem_q[wr_ptr_q] <= ep_data;
    end
  end

  assign ep_stall   = 1'b0;
  assign byte_valid = (count_q != '0);
  assign byte_data  = mem_q[rd_ptr_q];
  assign level      = count_q;

endmodule

// File: tb/tb_usb_out_ep_drain.sv
// Directed bench for usb_out_ep_drain: a small endpoint model feeds numbered bytes,
// and every pop is checked against the expected in-order byte value.
module tb_usb_out_ep_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       ep_data_avail;
  logic       ep_data_get;
  logic [7:0] ep_data;
  logic       ep_stall;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic [2:0] level;

  int         checks   = 0;
  int         failures = 0;
  int         gets     = 0;
  int         pops     = 0;
  int         get_idx  = 0;
  int         get_limit = 0;
  logic       avail_on = 1'b0;
  logic [7:0] src_base = 8'h00;
  logic [7:0] exp_next = 8'h00;
  logic       seen_aa  = 1'b0;

  usb_out_ep_drain #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ep_data_avail(ep_data_avail),
    .ep_data_get  (ep_data_get),
    .ep_data      (ep_data),
    .ep_stall     (ep_stall),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_data    (byte_data),
    .level        (level)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    ep_data_avail = avail_on && (get_idx < get_limit);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Called at the negedge: checks any pop, then advances one cycle and plays the endpoint.
  task automatic cyc();
    logic g;
    g = ep_data_get;
    if (!reset && byte_valid && byte_ready) begin
      if (byte_data === 8'hAA) seen_aa = 1'b1;
      chk("pop_order", {24'h0, byte_data}, {24'h0, exp_next});
      exp_next = exp_next + 8'd1;
      pops++;
    end
    @(posedge clk);
    #1;
    if (g) begin
      ep_data = src_base + 8'(get_idx);
      get_idx++;
      gets++;
    end else begin
      ep_data = 8'hEE;
    end
    upd();
  endtask

  task automatic start(input logic [7:0] base, input int limit);
    src_base  = base;
    exp_next  = base;
    get_idx   = 0;
    get_limit = limit;
    gets      = 0;
    pops      = 0;
    avail_on  = 1'b1;
    upd();
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    byte_ready = 1'b1;
    ep_data    = 8'hEE;
    get_limit  = 8;
    avail_on   = 1'b1;
    upd();

    // Reset state, with enable and avail high
    mid();
    chk("rst_get", ep_data_get, 0);
    chk("rst_stall", ep_stall, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_level", level, 0);
    cyc();
    mid();
    chk("rst_level2", level, 0);
    cyc();
    reset = 1'b0;

    // Single byte 0x5A
    start(8'h5A, 1);
    mid();
    chk("t1_get_n", ep_data_get, 1);
    chk("t1_level_n", level, 0);
    cyc(); mid();
    chk("t1_get_n1", ep_data_get, 0);
    chk("t1_valid_n1", byte_valid, 0);
    cyc(); mid();
    chk("t1_valid_n2", byte_valid, 1);
    chk("t1_data_n2", byte_data, 8'h5A);
    chk("t1_level_n2", level, 1);
    cyc(); mid();
    chk("t1_level_n3", level, 0);
    chk("t1_valid_n3", byte_valid, 0);
    chk("t1_pops", pops, 1);

    // Burst 0x00..0x1F with ready held high
    cyc();
    start(8'h00, 32);
    mid();
    for (int i = 0; i < 34; i++) begin
      chk("t2_get", ep_data_get, (i < 32));
      chk("t2_valid", byte_valid, (i >= 2));
      cyc(); mid();
    end
    chk("t2_valid_end", byte_valid, 0);
    chk("t2_level_end", level, 0);
    chk("t2_gets", gets, 32);
    chk("t2_pops", pops, 32);

    // Backpressure until full, then release
    cyc();
    byte_ready = 1'b0;
    start(8'h40, 10);
    mid();
    for (int i = 0; i < 8; i++) begin
      cyc(); mid();
    end
    chk("t3_gets_full", gets, 4);
    chk("t3_level_full", level, 4);
    chk("t3_get_full", ep_data_get, 0);
    chk("t3_head_full", byte_data, 8'h40);
    cyc();
    byte_ready = 1'b1;
    mid();
    chk("t3_get_pop_cycle", ep_data_get, 0);
    cyc(); mid();
    chk("t3_get_after_pop", ep_data_get, 1);
    chk("t3_level_after_pop", level, 3);
    for (int k = 0; k < 40; k++) begin
      if (pops == 10 && level == 3'd0) break;
      cyc(); mid();
    end
    chk("t3_gets", gets, 10);
    chk("t3_pops", pops, 10);
    chk("t3_level_end", level, 0);

    // Steady capture+pop at level 2 across several pointer wraps
    cyc();
    byte_ready = 1'b0;
    start(8'h80, 20);
    mid();
    cyc(); mid();
    cyc(); mid();
    cyc();
    byte_ready = 1'b1;
    mid();
    chk("t4_get_c3", ep_data_get, 1);
    for (int t = 3; t < 22; t++) begin
      chk("t4_level", level, 2);
      chk("t4_head", byte_data, 8'h80 + 8'(t - 3));
      cyc(); mid();
    end
    chk("t4_level_tail", level, 1);
    for (int k = 0; k < 20; k++) begin
      if (pops == 20 && level == 3'd0) break;
      cyc(); mid();
    end
    chk("t4_gets", gets, 20);
    chk("t4_pops", pops, 20);
    chk("t4_level_end", level, 0);

    // Reset while a byte (0xAA) is pending
    cyc();
    start(8'hAA, 1);
    mid();
    chk("t5_get", ep_data_get, 1);
    cyc();
    reset = 1'b1;
    mid();
    chk("t5_get_in_reset", ep_data_get, 0);
    cyc();
    reset = 1'b0;
    mid();
    chk("t5_valid", byte_valid, 0);
    chk("t5_level", level, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_valid_hold", byte_valid, 0);
      cyc(); mid();
    end
    chk("t5_pops", pops, 0);
    chk("t5_no_aa", seen_aa, 0);

    // enable dropped mid-burst
    cyc();
    start(8'hC0, 20);
    mid();
    chk("t6_get_c0", ep_data_get, 1);
    cyc(); mid();
    cyc(); mid();
    cyc();
    enable = 1'b0;
    mid();
    chk("t6_get_off", ep_data_get, 0);
    chk("t6_gets", gets, 3);
    for (int k = 0; k < 20; k++) begin
      if (pops == 3 && level == 3'd0) break;
      cyc(); mid();
    end
    chk("t6_pops", pops, 3);
    chk("t6_level_end", level, 0);
    chk("t6_valid_end", byte_valid, 0);
    chk("t6_gets_end", gets, 3);
    chk("t6_next", exp_next, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
